// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N_CH:1 channel multiplexer with manual select and
// an auto-scan sequencer that walks every channel, holding each for DWELL
// cycles.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   data_in    - packed channels, channel c at [c*DATA_W +: DATA_W]
//   mode       - 0 = manual (sel_in), 1 = auto-scan
//   sel_in     - manual channel select
//   start      - begin an auto scan (level-sampled in IDLE)
//   stop       - abort an auto scan (wins over start)
//   cont       - 1 = wrap and scan continuously, 0 = single frame
//   y          - registered selected data
//   sel_out    - channel index currently presented on y
//   valid      - y/sel_out carry a new sample this cycle
//   busy       - auto scan in progress
//   frame_done - pulse alongside the last channel of a frame
module mux_scan_seq #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 1,
  parameter int DWELL  = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cont,
  output logic [DATA_W-1:0]      y,
  output logic [SEL_W-1:0]       sel_out,
  output logic                   valid,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  // unpacked view of the flat channel bus
  logic [N_CH-1:0][DATA_W-1:0] ch_data;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_unpack
      assign ch_data[g] = data_in[g*DATA_W +: DATA_W];
    end
  endgenerate

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                fd_q, fd_d;
  logic                sel_ok;

  // only matters when N_CH is not a power of two
  assign sel_ok = (int'(sel_in) < N_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dwell_q <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;

    if (!mode) begin
      state_d = IDLE;
      ch_d    = '0;
      dwell_d = '0;
      // A scan interrupted by mode falling spends one edge aborting with
      // outputs held; manual selection takes over from the following edge.
      if (state_q == IDLE) begin
        sel_d = sel_in;
        if (sel_ok) begin
          y_d     = ch_data[sel_in];
          valid_d = 1'b1;
        end else begin
          y_d = '0;
        end
      end
    end else if (state_q == IDLE) begin
      if (start && !stop) begin
        state_d = SCAN;
        ch_d    = '0;
        dwell_d = '0;
      end
    end else if (stop) begin
      state_d = IDLE;
      ch_d    = '0;
      dwell_d = '0;
    end else begin
      // data is captured only on the first cycle of each dwell window
      if (dwell_q == '0) begin
        y_d     = ch_data[ch_q];
        sel_d   = ch_q;
        valid_d = 1'b1;
        fd_d    = (ch_q == LAST_CH);
      end
      if (dwell_q == LAST_DW) begin
        dwell_d = '0;
        if (ch_q == LAST_CH) begin
          ch_d = '0;
          if (!cont) state_d = IDLE;
        end else begin
          ch_d = ch_q + SEL_W'(1);
        end
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  assign y          = y_q;
  assign sel_out    = sel_q;
  assign valid      = valid_q;
  assign busy       = (state_q == SCAN);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: three instances (16ch/DWELL=1, 16ch/DWELL=3,
// 12ch/DWELL=1) share clock, reset and data; each has its own mode/start so
// only the instance under test produces samples. Expected samples are queued
// when stimulus is issued and popped by a monitor on every valid strobe.
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in;
  logic [3:0]  sel_in;
  logic        stop, cont;
  logic        mode_a, mode_b, mode_c;
  logic        start_a, start_b, start_c;

  logic       y_a, y_b, y_c;
  logic [3:0] sel_a, sel_b, sel_c;
  logic       valid_a, valid_b, valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       fd_a, fd_b, fd_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   sel;
    logic y;
    logic fd;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  mux_scan_seq #(.N_CH(16), .DATA_W(1), .DWELL(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode_a), .sel_in(sel_in),
    .start(start_a), .stop(stop), .cont(cont), .y(y_a), .sel_out(sel_a),
    .valid(valid_a), .busy(busy_a), .frame_done(fd_a));

  mux_scan_seq #(.N_CH(16), .DATA_W(1), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode_b), .sel_in(sel_in),
    .start(start_b), .stop(stop), .cont(cont), .y(y_b), .sel_out(sel_b),
    .valid(valid_b), .busy(busy_b), .frame_done(fd_b));

  mux_scan_seq #(.N_CH(12), .DATA_W(1), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_in[11:0]), .mode(mode_c), .sel_in(sel_in),
    .start(start_c), .stop(stop), .cont(cont), .y(y_c), .sel_out(sel_c),
    .valid(valid_c), .busy(busy_c), .frame_done(fd_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input int s, input logic yv, input logic f);
    exp_t e;
    e.sel = s;
    e.y   = yv;
    e.fd  = f;
    case (w)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (valid_a === 1'b1) begin
          if (q_a.size() == 0) chk("a_unexpected_valid", valid_a, 0);
          else begin
            e = q_a.pop_front();
            chk("a_sel", sel_a, e.sel);
            chk("a_y", y_a, e.y);
            chk("a_fd", fd_a, e.fd);
          end
        end else chk("a_fd_idle", fd_a, 0);
        if (valid_b === 1'b1) begin
          if (q_b.size() == 0) chk("b_unexpected_valid", valid_b, 0);
          else begin
            e = q_b.pop_front();
            chk("b_sel", sel_b, e.sel);
            chk("b_y", y_b, e.y);
            chk("b_fd", fd_b, e.fd);
          end
        end else chk("b_fd_idle", fd_b, 0);
        if (valid_c === 1'b1) begin
          if (q_c.size() == 0) chk("c_unexpected_valid", valid_c, 0);
          else begin
            e = q_c.pop_front();
            chk("c_sel", sel_c, e.sel);
            chk("c_y", y_c, e.y);
          end
        end
      end
    end
  endtask

  // 16'h5A5A, bits 0..15 written out by hand
  localparam logic [15:0] PAT = 16'b0101_1010_0101_1010;

  initial begin
    int nv, pat_err, fd_at;
    data_in = 16'hAAAA;
    sel_in  = '0;
    stop    = 1'b0;
    cont    = 1'b0;
    mode_a  = 1'b1;
    mode_b  = 1'b1;
    mode_c  = 1'b1;
    start_a = 1'b1;
    start_b = 1'b0;
    start_c = 1'b0;
    rst     = 1'b1;
    fork
      monitor();
    join_none

    // reset with start/mode asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", y_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_fd", fd_a, 0);
    step();
    rst = 1'b0;
    start_a = 1'b0;

    // manual sweep, AAAA -> 0,1,0,1...
    step();
    mode_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel_in = 4'(i);
      push(0, i, 1'(i % 2), 1'b0);
      step();
    end
    chk("man_busy", busy_a, 0);
    mode_a = 1'b1;

    // single auto frame, DWELL=1
    step();
    cont = 1'b0;
    start_a = 1'b1;
    for (int c = 0; c < 16; c++) push(0, c, 1'(c % 2), (c == 15));
    step();
    start_a = 1'b0;
    chk("frame_busy", busy_a, 1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("frame_busy_end", busy_a, 0);

    // DWELL=3 frame on dut_b
    step();
    start_b = 1'b1;
    for (int c = 0; c < 16; c++) push(1, c, 1'(c % 2), (c == 15));
    step();
    start_b = 1'b0;
    nv = 0; pat_err = 0; fd_at = -1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_b === 1'b1) nv++;
      if (valid_b !== (((k - 1) % 3) == 0)) pat_err++;
      if (fd_b === 1'b1) fd_at = k;
      if (k == 47) chk("dwell_busy47", busy_b, 1);
    end
    chk("dwell_nvalid", nv, 16);
    chk("dwell_pattern_err", pat_err, 0);
    chk("dwell_fd_cycle", fd_at, 46);
    chk("dwell_busy_end", busy_b, 0);

    // continuous scan then stop at channel 6 of the second frame
    step();
    data_in = 16'h5A5A;
    cont = 1'b1;
    start_a = 1'b1;
    for (int k = 0; k < 23; k++) push(0, k % 16, PAT[k % 16], ((k % 16) == 15));
    step();
    start_a = 1'b0;
    nv = 0;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_a === 1'b1) nv++;
    end
    chk("cont_no_gap", nv, 23);
    chk("cont_sel6", sel_a, 6);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stop_busy", busy_a, 0);
    chk("stop_valid", valid_a, 0);
    chk("stop_sel_hold", sel_a, 6);
    chk("stop_y_hold", y_a, 1);
    stop = 1'b0;

    // start and stop together while idle
    step();
    start_a = 1'b1;
    stop = 1'b1;
    step();
    start_a = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy_a, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ss_busy2", busy_a, 0);
    chk("ss_valid", valid_a, 0);

    // reset mid-scan at channel 9
    step();
    start_a = 1'b1;
    for (int k = 0; k < 10; k++) push(0, k, PAT[k], 1'b0);
    step();
    start_a = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_sel9", sel_a, 9);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_y", y_a, 0);
    chk("mid_rst_sel", sel_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_fd", fd_a, 0);
    #1 rst = 1'b0;

    // mode dropped mid-scan at channel 4
    step();
    start_a = 1'b1;
    for (int k = 0; k < 5; k++) push(0, k, PAT[k], 1'b0);
    step();
    start_a = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("md_sel4", sel_a, 4);
    mode_a = 1'b0;
    sel_in = 4'd3;
    @(posedge clk);
    @(negedge clk);
    chk("md_abort_busy", busy_a, 0);
    chk("md_abort_valid", valid_a, 0);
    chk("md_abort_sel", sel_a, 4);
    push(0, 3, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("md_manual_busy", busy_a, 0);
    #1 mode_a = 1'b1;
    cont = 1'b0;

    // 12-channel instance: out-of-range select
    step();
    data_in = 16'h0820;
    mode_c = 1'b0;
    sel_in = 4'd5;
    push(2, 5, 1'b1, 1'b0);
    step();
    sel_in = 4'd13;
    @(posedge clk);
    @(negedge clk);
    chk("n12_oor_valid", valid_c, 0);
    chk("n12_oor_y", y_c, 0);
    chk("n12_oor_sel", sel_c, 13);
    sel_in = 4'd11;
    push(2, 11, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 mode_c = 1'b1;

    step();
    step();
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_c_drained", q_c.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Parametrised, registered N:1 channel multiplexer. Successor to the fixed 16x1 combinational mux.
- Two modes:
  - Manual: select is driven externally.
  - Auto-scan: an internal sequencer steps through all channels, holding each one for a programmable dwell time.
- Sits between parallel data sources and a single serial consumer. The consumer samples y when valid is high.

Parameters:
- N_CH, 16: number of input channels; N_CH >= 2.
- DATA_W, 1: width of each channel in bits.
- DWELL, 1: clock cycles each channel is held in auto mode; DWELL >= 1.
- SEL_W (localparam): $clog2(N_CH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  N_CH*DATA_W  packed channels; channel c occupies bits [c*DATA_W +: DATA_W].
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  SEL_W  channel select, used in manual mode.
- start  in  1  begins an auto scan (level-sampled).
- stop  in  1  aborts an auto scan.
- cont  in  1  1 = wrap around and scan continuously; 0 = single frame.
- y  out  DATA_W  registered selected data.
- sel_out  out  SEL_W  channel index currently presented on y.
- valid  out  1  strobe: y/sel_out updated with a new sample.
- busy  out  1  auto scan in progress.
- frame_done  out  1  one-cycle pulse with the last channel of a frame.

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - y=0, sel_out=0, valid=0, busy=0, frame_done=0.
  - State IDLE, internal channel counter=0, dwell counter=0.
  - rst overrides all other inputs, including mid-scan.
- States: IDLE and SCAN. busy = (state==SCAN), registered.
- Manual mode (mode=0):
  - State is forced to IDLE.
  - Every edge: y <= channel[sel_in], sel_out <= sel_in, valid <= 1. Latency is 1 cycle.
  - If sel_in >= N_CH: y <= 0, sel_out <= sel_in, valid <= 0.
  - frame_done stays 0.
- Auto mode (mode=1), IDLE state:
  - valid=0 and frame_done=0; y and sel_out hold their values.
  - start=1 and stop=0 at an edge: go to SCAN with ch=0, dwell=0. No output change on that edge.
- Auto mode, SCAN state, each edge:
  - If stop=1 or mode has fallen to 0: go to IDLE next edge. y and sel_out hold; valid=0, frame_done=0.
  - Otherwise:
    - If dwell==0: y <= channel[ch], sel_out <= ch, valid <= 1, frame_done <= (ch==N_CH-1).
    - If dwell!=0: valid <= 0 and frame_done <= 0; y holds.
    - If dwell==DWELL-1: dwell <= 0 and ch advances. Otherwise dwell increments.
    - On advancing from ch==N_CH-1: with cont=1, ch <= 0 and the scan continues with no gap cycle; with cont=0, go to IDLE.
- Timing:
  - First sample appears on the edge after start is accepted.
  - A frame spans N_CH*DWELL cycles.
  - With DWELL=1, valid stays high continuously during the scan.
- Boundary cases:
  - start while busy: ignored.
  - start and stop at the same edge (IDLE or SCAN): stop wins, result is IDLE.
  - cont may change mid-frame; it is sampled only at the frame-end advance.
  - data_in is sampled on the dwell==0 edge only and is not re-sampled during the dwell.
  - sel_in is ignored in auto mode.

Test Plan:
- Reset: drive rst=1 for 2 edges with start=1, mode=1, data_in=16'hAAAA → y=0, sel_out=0, valid=0, busy=0, frame_done=0.
- Manual (N_CH=16, DATA_W=1), data_in=16'hAAAA, sel_in stepping 0..15 one per cycle → one cycle later y = 0,1,0,1,..., sel_out tracks sel_in, valid=1 throughout. Rebuild with N_CH=12, sel_in=13 → y=0, valid=0.
- Auto single frame (DWELL=1, cont=0, data_in=16'hAAAA), start pulse → 16 consecutive valid cycles with sel_out 0..15 and y alternating 0,1. frame_done=1 only with sel_out=15. busy=0 on the following edge.
- Dwell (DWELL=3) → each channel held for 3 cycles. valid is high only on the first of each 3. frame_done asserts at cycle 46 after start. Total frame is 48 cycles.
- Continuous and stop (cont=1, DWELL=1):
  - sel_out wraps 15→0 with no idle cycle; frame_done fires every 16 cycles.
  - Assert stop when sel_out=6 → next edge busy=0, valid=0, y/sel_out hold at channel 6.
- Simultaneous events:
  - start and stop together while IDLE → stays IDLE.
  - rst at sel_out=9 mid-scan → all outputs 0 next edge.
  - mode dropped to 0 mid-scan → scan aborts, manual output follows sel_in from the next edge.
